// File: rtl/position_control.sv
// Player position controller: turns direction key pulses into a tile-map move request,
// waits for the legality verdict and commits a legal move by rewriting two tiles.
module position_control #(
  parameter int MAX_COORD = 23,
  parameter int START_X   = 0,
  parameter int START_Y   = 0,
  parameter int TIMEOUT   = 63
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       externalReset,
  input  logic       keyLeft,
  input  logic       keyRight,
  input  logic       keyUp,
  input  logic       keyDown,
  input  logic       doneCheckLegal,
  input  logic       isLegal,
  input  logic       gameWon,
  input  logic       gameOver,
  output logic [4:0] x,
  output logic [4:0] y,
  output logic       moveLeft,
  output logic       moveRight,
  output logic       moveUp,
  output logic       moveDown,
  output logic       doneChangePosition,
  output logic [9:0] memAddress,
  output logic [2:0] memWriteData,
  output logic       memWriteEn,
  output logic       moveTaken,
  output logic       busy
);

  localparam int              CNT_W         = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] TIMEOUT_C    = CNT_W'(TIMEOUT);
  localparam logic [4:0]      MAX_C         = 5'(MAX_COORD);
  localparam logic [4:0]      START_XC      = 5'(START_X);
  localparam logic [4:0]      START_YC      = 5'(START_Y);
  localparam logic [2:0]      AVAILABLE     = 3'd1;
  localparam logic [2:0]      YOUR_POSITION = 3'd4;

  typedef enum logic [3:0] {
    IDLE, LATCH, READ_WAIT, PRESENT, WAIT_CHECK, ERASE, DRAW, DONE, HALT
  } state_t;

  state_t           state, nextState;
  logic [3:0]       dir, dirNxt;
  logic [3:0]       keyDir;
  logic             anyKey;
  logic [4:0]       stepX, stepY;
  logic [4:0]       candX, candY, candXNxt, candYNxt;
  logic [4:0]       xNxt, yNxt;
  logic [CNT_W-1:0] count, countNxt;
  logic [9:0]       addrNxt;
  logic [2:0]       wdNxt;
  logic             weNxt, dcpNxt, takenNxt, busyNxt;

  // dir is one-hot {up, down, left, right}
  assign {moveUp, moveDown, moveLeft, moveRight} = dir;

  always_comb begin
    keyDir = 4'b0000;
    if (keyUp)         keyDir = 4'b1000;
    else if (keyDown)  keyDir = 4'b0100;
    else if (keyLeft)  keyDir = 4'b0010;
    else if (keyRight) keyDir = 4'b0001;
  end

  assign anyKey = |keyDir;

  // A move into the border yields the current tile; the checker rejects it.
  always_comb begin
    stepX = x;
    stepY = y;
    if (dir[3]) begin
      if (y != 5'd0) stepY = y - 5'd1;
    end else if (dir[2]) begin
      if (y != MAX_C) stepY = y + 5'd1;
    end else if (dir[1]) begin
      if (x != 5'd0) stepX = x - 5'd1;
    end else if (dir[0]) begin
      if (x != MAX_C) stepX = x + 5'd1;
    end
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE: begin
        if (gameWon || gameOver) nextState = HALT;
        else if (anyKey)         nextState = LATCH;
      end
      LATCH:     nextState = READ_WAIT;
      READ_WAIT: nextState = PRESENT;
      PRESENT:   nextState = WAIT_CHECK;
      WAIT_CHECK: begin
        if (doneCheckLegal && isLegal) nextState = ERASE;
        else if (doneCheckLegal)       nextState = IDLE;
        else if (gameOver)             nextState = HALT;
        else if (count == TIMEOUT_C)   nextState = IDLE;
      end
      ERASE:   nextState = DRAW;
      DRAW:    nextState = DONE;
      DONE:    nextState = IDLE;
      HALT:    nextState = HALT;
      default: nextState = IDLE;
    endcase
    if (externalReset) nextState = IDLE;
  end

  // Output values for the coming cycle, registered below.
  always_comb begin
    xNxt     = x;
    yNxt     = y;
    dirNxt   = dir;
    candXNxt = candX;
    candYNxt = candY;
    countNxt = count;
    addrNxt  = memAddress;
    wdNxt    = memWriteData;
    weNxt    = 1'b0;
    dcpNxt   = 1'b0;
    takenNxt = 1'b0;
    busyNxt  = (nextState != IDLE) && (nextState != HALT);
    case (state)
      IDLE: begin
        if (nextState == LATCH) dirNxt = keyDir;
      end
      LATCH: begin
        candXNxt = stepX;
        candYNxt = stepY;
        addrNxt  = {stepY, stepX};
      end
      READ_WAIT: dcpNxt = 1'b1;
      PRESENT:   countNxt = '0;
      WAIT_CHECK: begin
        countNxt = count + CNT_W'(1);
        if (nextState == ERASE) begin
          addrNxt = {y, x};
          wdNxt   = AVAILABLE;
          weNxt   = 1'b1;
        end else if (nextState != WAIT_CHECK) begin
          dirNxt = 4'b0000;
        end
      end
      ERASE: begin
        addrNxt = {candY, candX};
        wdNxt   = YOUR_POSITION;
        weNxt   = 1'b1;
      end
      DRAW: begin
        xNxt     = candX;
        yNxt     = candY;
        takenNxt = 1'b1;
        dirNxt   = 4'b0000;
      end
      default: ;
    endcase
    if (externalReset) begin
      xNxt     = START_XC;
      yNxt     = START_YC;
      dirNxt   = 4'b0000;
      countNxt = '0;
      addrNxt  = {START_YC, START_XC};
      wdNxt    = 3'd0;
      weNxt    = 1'b0;
      dcpNxt   = 1'b0;
      takenNxt = 1'b0;
      busyNxt  = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state              <= IDLE;
      x                  <= START_XC;
      y                  <= START_YC;
      dir                <= 4'b0000;
      candX              <= START_XC;
      candY              <= START_YC;
      count              <= '0;
      memAddress         <= {START_YC, START_XC};
      memWriteData       <= 3'd0;
      memWriteEn         <= 1'b0;
      doneChangePosition <= 1'b0;
      moveTaken          <= 1'b0;
      busy               <= 1'b0;
    end else begin
      state              <= nextState;
      x                  <= xNxt;
      y                  <= yNxt;
      dir                <= dirNxt;
      candX              <= candXNxt;
      candY              <= candYNxt;
      count              <= countNxt;
      memAddress         <= addrNxt;
      memWriteData       <= wdNxt;
      memWriteEn         <= weNxt;
      doneChangePosition <= dcpNxt;
      moveTaken          <= takenNxt;
      busy               <= busyNxt;
    end
  end

endmodule

// File: tb/tb_position_control.sv
// Bench for position_control: timestamp-based transaction model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_position_control;

  localparam int MAX_COORD = 23;
  localparam int START_X   = 0;
  localparam int START_Y   = 0;
  localparam int TIMEOUT   = 63;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic       externalReset = 1'b0;
  logic       keyLeft = 1'b0, keyRight = 1'b0, keyUp = 1'b0, keyDown = 1'b0;
  logic       doneCheckLegal = 1'b0, isLegal = 1'b0;
  logic       gameWon = 1'b0, gameOver = 1'b0;
  logic [4:0] x, y;
  logic       moveLeft, moveRight, moveUp, moveDown;
  logic       doneChangePosition;
  logic [9:0] memAddress;
  logic [2:0] memWriteData;
  logic       memWriteEn, moveTaken, busy;

  always #5 clock = ~clock;

  position_control #(
    .MAX_COORD(MAX_COORD), .START_X(START_X), .START_Y(START_Y), .TIMEOUT(TIMEOUT)
  ) dut (
    .clock(clock), .resetn(resetn), .externalReset(externalReset),
    .keyLeft(keyLeft), .keyRight(keyRight), .keyUp(keyUp), .keyDown(keyDown),
    .doneCheckLegal(doneCheckLegal), .isLegal(isLegal),
    .gameWon(gameWon), .gameOver(gameOver),
    .x(x), .y(y),
    .moveLeft(moveLeft), .moveRight(moveRight), .moveUp(moveUp), .moveDown(moveDown),
    .doneChangePosition(doneChangePosition),
    .memAddress(memAddress), .memWriteData(memWriteData), .memWriteEn(memWriteEn),
    .moveTaken(moveTaken), .busy(busy)
  );

  int   checks = 0;
  int   errors = 0;
  logic checkEn = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Tile memory and event counters observed from the DUT's outputs.
  logic [2:0] tile [0:1023];
  int writeCount = 0, dcpCount = 0, takenCount = 0;

  always @(posedge clock) begin
    if (resetn) begin
      if (memWriteEn) begin
        tile[memAddress] <= memWriteData;
        writeCount <= writeCount + 1;
      end
      if (doneChangePosition) dcpCount <= dcpCount + 1;
      if (moveTaken) takenCount <= takenCount + 1;
    end
  end

  // Transaction model: a move accepted at edge acc has its request pulse two cycles
  // later; a legal verdict sampled at edge verd yields writes at verd, verd+1 and the
  // commit pulse at verd+2; a missing verdict is abandoned at edge acc+67.
  int         cyc = 0, acc = 0, verd = -1;
  bit         active = 1'b0, halted = 1'b0;
  logic [4:0] mx = 5'(START_X), my = 5'(START_Y), cx = 5'd0, cy = 5'd0;
  logic [3:0] mDir = 4'b0000;
  logic [9:0] mAddr = {5'(START_Y), 5'(START_X)};

  always @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      active = 1'b0; halted = 1'b0; verd = -1;
      mx = 5'(START_X); my = 5'(START_Y); mDir = 4'b0000;
      mAddr = {5'(START_Y), 5'(START_X)};
    end else begin
      cyc++;
      if (externalReset) begin
        active = 1'b0; halted = 1'b0; verd = -1;
        mx = 5'(START_X); my = 5'(START_Y); mDir = 4'b0000;
        mAddr = {5'(START_Y), 5'(START_X)};
      end else if (halted) begin
        halted = 1'b1;
      end else if (!active) begin
        if (gameWon || gameOver) halted = 1'b1;
        else if (keyUp || keyDown || keyLeft || keyRight) begin
          active = 1'b1; acc = cyc; verd = -1;
          cx = mx; cy = my;
          if (keyUp) begin
            mDir = 4'b1000; if (my > 0) cy = my - 5'd1;
          end else if (keyDown) begin
            mDir = 4'b0100; if (my < MAX_COORD) cy = my + 5'd1;
          end else if (keyLeft) begin
            mDir = 4'b0010; if (mx > 0) cx = mx - 5'd1;
          end else begin
            mDir = 4'b0001; if (mx < MAX_COORD) cx = mx + 5'd1;
          end
        end
      end else begin
        if (cyc == acc + 1) mAddr = {cy, cx};
        if (verd < 0) begin
          if (cyc >= acc + 4) begin
            if (doneCheckLegal && isLegal) begin
              verd = cyc; mAddr = {my, mx};
            end else if (doneCheckLegal) begin
              active = 1'b0; mDir = 4'b0000;
            end else if (gameOver) begin
              active = 1'b0; halted = 1'b1; mDir = 4'b0000;
            end else if (cyc == acc + 4 + TIMEOUT) begin
              active = 1'b0; mDir = 4'b0000;
            end
          end
        end else begin
          if (cyc == verd + 1) mAddr = {cy, cx};
          else if (cyc == verd + 2) begin mx = cx; my = cy; end
          else if (cyc == verd + 3) begin active = 1'b0; mDir = 4'b0000; end
        end
      end
    end
  end

  always @(negedge clock) begin : compare
    bit d, w, t;
    if (checkEn) begin
      d = active && (cyc == acc + 2);
      w = active && (verd >= 0) && (cyc == verd || cyc == verd + 1);
      t = active && (verd >= 0) && (cyc == verd + 2);
      check("x", 32'(x), 32'(mx));
      check("y", 32'(y), 32'(my));
      check("busy", 32'(busy), 32'(active));
      check("doneChangePosition", 32'(doneChangePosition), 32'(d));
      check("memWriteEn", 32'(memWriteEn), 32'(w));
      check("moveTaken", 32'(moveTaken), 32'(t));
      check("moveDir", 32'({moveUp, moveDown, moveLeft, moveRight}),
            32'((active && !t) ? mDir : 4'b0000));
      check("memAddress", 32'(memAddress), 32'(mAddr));
      if (w) check("memWriteData", 32'(memWriteData), (cyc == verd) ? 32'd1 : 32'd4);
    end
  end

  // k = {up, down, left, right}; returns cycles from key to request pulse.
  task automatic sendKey(input logic [3:0] k, output int lat);
    @(negedge clock);
    {keyUp, keyDown, keyLeft, keyRight} = k;
    lat = 0;
    @(negedge clock);
    {keyUp, keyDown, keyLeft, keyRight} = 4'b0000;
    lat = 1;
    while (!doneChangePosition && lat < 10) begin
      @(negedge clock);
      lat++;
    end
    check("dcp_arrival", 32'(doneChangePosition), 32'd1);
  endtask

  // Returns cycles from verdict to commit pulse for a legal verdict.
  task automatic verdict(input logic legal, output int lat);
    @(negedge clock);
    doneCheckLegal = 1'b1; isLegal = legal;
    lat = 0;
    @(negedge clock);
    doneCheckLegal = 1'b0; isLegal = 1'b0;
    lat = 1;
    if (legal) begin
      while (!moveTaken && lat < 10) begin
        @(negedge clock);
        lat++;
      end
      check("taken_arrival", 32'(moveTaken), 32'd1);
    end
  endtask

  task automatic doMove(input logic [3:0] k, input logic legal);
    int l;
    sendKey(k, l);
    verdict(legal, l);
  endtask

  task automatic pulseExtReset();
    @(negedge clock);
    externalReset = 1'b1;
    @(negedge clock);
    externalReset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, d0, w0;
    for (int i = 0; i < 1024; i++) tile[i] = 3'd0;
    resetn = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_x", 32'(x), 32'd0);
    check("rst_y", 32'(y), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_addr", 32'(memAddress), 32'd0);
    check("rst_wdata", 32'(memWriteData), 32'd0);
    check("rst_we", 32'(memWriteEn), 32'd0);
    check("rst_dcp", 32'(doneChangePosition), 32'd0);
    check("rst_taken", 32'(moveTaken), 32'd0);
    check("rst_dir", 32'({moveUp, moveDown, moveLeft, moveRight}), 32'd0);
    resetn = 1'b1;
    checkEn = 1'b1;
    repeat (2) @(negedge clock);

    // Left at the border: candidate stays on the current tile, checker rejects.
    sendKey(4'b0010, lat);
    check("left_dir", 32'({moveUp, moveDown, moveLeft, moveRight}), 32'b0010);
    check("left_addr", 32'(memAddress), 32'd0);
    verdict(1'b0, lat);
    check("left_cleared", 32'({moveUp, moveDown, moveLeft, moveRight}), 32'd0);
    check("left_writes", 32'(writeCount), 32'd0);
    check("left_x", 32'(x), 32'd0);

    // Legal right move from (0,0).
    sendKey(4'b0001, lat);
    check("right_latency", 32'(lat), 32'd3);
    check("right_dir", 32'({moveUp, moveDown, moveLeft, moveRight}), 32'b0001);
    check("right_addr", 32'(memAddress), 32'd1);
    verdict(1'b1, lat);
    check("legal_latency", 32'(lat), 32'd3);
    check("right_x", 32'(x), 32'd1);
    check("right_y", 32'(y), 32'd0);
    @(negedge clock);
    check("erase_tile", 32'(tile[0]), 32'd1);
    check("draw_tile", 32'(tile[1]), 32'd4);
    check("right_writes", 32'(writeCount), 32'd2);
    check("right_taken", 32'(takenCount), 32'd1);

    // Walk to (5,5).
    for (int i = 0; i < 4; i++) doMove(4'b0001, 1'b1);
    for (int i = 0; i < 5; i++) doMove(4'b0100, 1'b1);
    check("walk_x", 32'(x), 32'd5);
    check("walk_y", 32'(y), 32'd5);

    // Up and left together: up wins.
    sendKey(4'b1010, lat);
    check("prio_dir", 32'({moveUp, moveDown, moveLeft, moveRight}), 32'b1000);
    check("prio_addr", 32'(memAddress), 32'({5'd4, 5'd5}));
    verdict(1'b0, lat);

    // A key arriving while waiting for the verdict is dropped.
    d0 = dcpCount;
    sendKey(4'b0100, lat);
    @(negedge clock); keyRight = 1'b1;
    @(negedge clock); keyRight = 1'b0;
    verdict(1'b1, lat);
    repeat (3) @(negedge clock);
    check("single_dcp", 32'(dcpCount - d0), 32'd1);
    check("drop_x", 32'(x), 32'd5);
    check("drop_y", 32'(y), 32'd6);

    // No verdict: move is abandoned, then a new key is accepted.
    w0 = writeCount;
    sendKey(4'b0100, lat);
    repeat (70) @(negedge clock);
    check("timeout_busy", 32'(busy), 32'd0);
    check("timeout_writes", 32'(writeCount - w0), 32'd0);
    check("timeout_y", 32'(y), 32'd6);
    doMove(4'b0100, 1'b1);
    check("after_timeout_y", 32'(y), 32'd7);

    // gameWon during the check: move completes, then keys are ignored.
    sendKey(4'b0001, lat);
    gameWon = 1'b1;
    verdict(1'b1, lat);
    check("won_x", 32'(x), 32'd6);
    repeat (3) @(negedge clock);
    d0 = dcpCount;
    @(negedge clock); keyLeft = 1'b1;
    @(negedge clock); keyLeft = 1'b0;
    repeat (6) @(negedge clock);
    check("won_halt_dcp", 32'(dcpCount - d0), 32'd0);
    check("won_halt_busy", 32'(busy), 32'd0);
    gameWon = 1'b0;
    pulseExtReset();
    check("restart_x", 32'(x), 32'd0);
    check("restart_y", 32'(y), 32'd0);
    check("restart_addr", 32'(memAddress), 32'd0);
    doMove(4'b0001, 1'b1);
    check("restart_move_x", 32'(x), 32'd1);

    // gameOver while waiting: halt without writes.
    w0 = writeCount;
    sendKey(4'b0001, lat);
    @(negedge clock); gameOver = 1'b1;
    @(negedge clock); gameOver = 1'b0;
    repeat (2) @(negedge clock);
    check("over_busy", 32'(busy), 32'd0);
    d0 = dcpCount;
    @(negedge clock); keyDown = 1'b1;
    @(negedge clock); keyDown = 1'b0;
    repeat (6) @(negedge clock);
    check("over_halt_dcp", 32'(dcpCount - d0), 32'd0);
    check("over_writes", 32'(writeCount - w0), 32'd0);
    check("over_x", 32'(x), 32'd1);
    pulseExtReset();
    check("over_restart_x", 32'(x), 32'd0);

    // Asynchronous reset in the middle of the second write.
    w0 = writeCount;
    sendKey(4'b0100, lat);
    @(negedge clock); doneCheckLegal = 1'b1; isLegal = 1'b1;
    @(negedge clock); doneCheckLegal = 1'b0; isLegal = 1'b0;
    @(negedge clock);
    check("draw_we", 32'(memWriteEn), 32'd1);
    check("draw_wdata", 32'(memWriteData), 32'd4);
    #2 resetn = 1'b0;
    #1;
    check("async_x", 32'(x), 32'd0);
    check("async_y", 32'(y), 32'd0);
    check("async_we", 32'(memWriteEn), 32'd0);
    check("async_busy", 32'(busy), 32'd0);
    check("async_addr", 32'(memAddress), 32'd0);
    check("async_dir", 32'({moveUp, moveDown, moveLeft, moveRight}), 32'd0);
    @(negedge clock);
    resetn = 1'b1;
    repeat (2) @(negedge clock);
    check("async_writes", 32'(writeCount - w0), 32'd1);
    doMove(4'b0001, 1'b1);
    check("async_recover_x", 32'(x), 32'd1);
    repeat (2) @(negedge clock);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/position_control.md
Name: position_control

Overview:
- Upstream stage of the legality checker; turns one-cycle direction key pulses into a move request.
- Presents current position, move direction and the memory address of the candidate tile.
- Pulses doneChangePosition and waits for the checker's verdict (doneCheckLegal/isLegal).
- Legal move: erases old tile, draws player on new tile, updates x/y, emits moveTaken for the downstream move counter.

Parameters:
- MAX_COORD, 23, highest legal x/y coordinate (24x24 grid)
- START_X, 0, x coordinate after reset
- START_Y, 0, y coordinate after reset
- TIMEOUT, 63, max cycles to wait for doneCheckLegal before abandoning the move

Ports:
- clock  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- externalReset  in  1  synchronous game restart, active-high
- keyLeft, keyRight, keyUp, keyDown  in  1 each  single-cycle direction pulses
- doneCheckLegal  in  1  checker verdict valid
- isLegal  in  1  verdict; sampled only with doneCheckLegal
- gameWon, gameOver  in  1 each  terminal status from checker
- x, y  out  5 each  current player position
- moveLeft, moveRight, moveUp, moveDown  out  1 each  one-hot latched request direction
- doneChangePosition  out  1  one-cycle request pulse to checker
- memAddress  out  10  {y_addr, x_addr}, 5+5 bits
- memWriteData  out  3  tile code to write
- memWriteEn  out  1  tile memory write strobe
- moveTaken  out  1  one-cycle pulse per committed move
- busy  out  1  high in every state except IDLE and HALT

Behaviour:
- Reset (resetn low, async):
  - state=IDLE; x=START_X, y=START_Y.
  - All move*, doneChangePosition, memWriteEn, moveTaken, busy = 0.
  - memAddress={START_Y,START_X}; memWriteData=0; timeout counter=0.
- All outputs are registered.
- Tile codes: AVAILABLE=3'd1, YOUR_POSITION=3'd4.
- Memory: synchronous read, 1-cycle latency; writes take effect at the clock edge with memWriteEn high.
- Candidate position computed at LATCH:
  - x-1 / x+1 / y-1 / y+1 per direction.
  - At a border (x=0 & left, x=MAX_COORD & right, y=0 & up, y=MAX_COORD & down) candidate = current; never wraps. The checker rejects the move.
- States:
  - IDLE:
    - Any key pulse -> LATCH; keys captured same edge.
    - Simultaneous keys: priority Up > Down > Left > Right, exactly one move* set.
    - gameWon or gameOver high -> HALT, takes precedence over keys.
  - LATCH: memAddress <= candidate -> READ_WAIT.
  - READ_WAIT: one cycle for read data -> PRESENT.
  - PRESENT:
    - doneChangePosition=1 for exactly this cycle -> WAIT_CHECK; counter cleared.
    - x/y still show the current position; memAddress holds the candidate until the move resolves.
  - WAIT_CHECK:
    - doneCheckLegal&isLegal -> ERASE.
    - doneCheckLegal&!isLegal -> IDLE, move* cleared, no writes.
    - gameOver -> HALT.
    - Counter reaches TIMEOUT -> IDLE, move* cleared, no writes.
  - ERASE: memAddress={y,x}, memWriteData=AVAILABLE, memWriteEn=1 -> DRAW.
  - DRAW:
    - memAddress=candidate, memWriteData=YOUR_POSITION, memWriteEn=1.
    - x,y <= candidate -> DONE.
  - DONE: moveTaken=1 for one cycle, move* cleared -> IDLE.
  - HALT:
    - No key response, no writes; busy=0.
    - Exit only by resetn or externalReset.
- Key pulses arriving in any state other than IDLE are dropped, not queued.
- Latency: key pulse to doneChangePosition = 3 cycles. Legal verdict to moveTaken = 3 cycles.
- externalReset high at any edge, any state (highest priority after resetn):
  - state=IDLE, x/y=START, all strobes 0, counter 0.
  - No memory write; the tile map is reloaded by the maze loader.
  - If externalReset arrives mid-ERASE/DRAW, the pending write is not issued.
- memWriteEn is high only in ERASE and DRAW: exactly 2 writes per committed move, 0 otherwise.
- gameWon arriving during WAIT_CHECK/ERASE/DRAW: the move completes normally (the checker reports the win after LEGAL), then IDLE -> HALT.

Test Plan:
- Reset, pulse keyRight at (0,0):
  - doneChangePosition 3 cycles later with moveRight=1 and memAddress={0,1}.
  - Drive doneCheckLegal=1, isLegal=1 -> writes (0,0)<=1 then (0,1)<=4; x=1,y=0; one moveTaken pulse.
- At (0,0) pulse keyLeft:
  - memAddress={0,0} (no wrap).
  - doneCheckLegal=1, isLegal=0 -> no memWriteEn, x/y unchanged, moveLeft cleared, back to IDLE.
- keyUp and keyLeft in the same cycle at (5,5) -> only moveUp=1, memAddress={4,5}.
- Second key pulse while in WAIT_CHECK -> ignored; exactly one doneChangePosition per accepted key.
- No doneCheckLegal for 64 cycles -> return to IDLE, no writes, busy=0. Then a new keyDown is accepted.
- Terminal and restart cases:
  - gameOver during WAIT_CHECK -> HALT; keys ignored.
  - externalReset 1 cycle -> x=START_X, y=START_Y, IDLE.
  - resetn low mid-DRAW -> immediate async return to reset values.
